// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared encodings for the CPU memory port
package cpu_mem_pkg;
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;
   localparam logic LANE_HHI = 1'b1;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lane);
      return (size == SIZE_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian load extract/extend and sub-word store merge
module mem_lane_align
   import cpu_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);
   logic [4:0]  sh;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] mask;
   // shift the addressed lane down for loads, and up into place for stores
   always_comb begin
      sh = lane_shift(size, lane);
      b = 8'(word >> sh);
      h = (lane[1] == LANE_HHI) ? word[31:16] : word[15:0];
      load_data = (size == SIZE_BYTE) ? {{24{sign & b[7]}}, b} :
                  (size == SIZE_HALF) ? {{16{sign & h[15]}}, h} : word;
      mask = ((size == SIZE_BYTE) ? 32'h0000_00FF :
              (size == SIZE_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
      merged = (word & ~mask) | ((wdata << sh) & mask);
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store requests to word-wide memory cycles with RMW sub-word stores
module mem_access_unit
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ROM_END      = 64000,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic        mem_write,
   output logic [31:0] mem_data_out,
   input  logic [31:0] mem_data_in
);
   localparam logic [7:0] LAT = 8'(READ_LATENCY);
   state_t      state, next;
   logic [31:0] addr_q, wdata_q, rdata_q, wword_q, load_data, merged;
   logic [1:0]  size_q;
   logic [7:0]  cnt;
   logic        write_q, sign_q, fault_q, fault, accept, last;

   mem_lane_align u_align (
      .word(mem_data_in),
      .lane(addr_q[1:0]),
      .size(size_q),
      .sign(sign_q),
      .wdata(wdata_q),
      .load_data(load_data),
      .merged(merged)
   );

   // next state and outputs decoded from state so reset clears them immediately
   always_comb begin
      fault = (req_size == SIZE_RSVD) | ((req_size == SIZE_HALF) & req_addr[0]) |
              ((req_size == SIZE_WORD) & (|req_addr[1:0])) | (req_write & (req_addr < ROM_END));
      accept = req_valid & (state == IDLE);
      last = cnt == LAT;
      next = state;
      case (state)
         IDLE:    if (req_valid) next = fault ? RESP : (req_write & (req_size == SIZE_WORD)) ? WRITE : READ;
         READ:    if (last) next = write_q ? WRITE : RESP;
         WRITE:   next = RESP;
         default: next = IDLE;
      endcase
      req_ready = state == IDLE;
      resp_valid = state == RESP;
      resp_fault = resp_valid & fault_q;
      resp_rdata = (resp_valid & ~fault_q & ~write_q) ? rdata_q : '0;
      mem_address = ((state != IDLE) & ~fault_q) ? {addr_q[31:2], 2'b00} : '0;
      mem_write = state == WRITE;
      mem_data_out = wword_q;
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= next;
   end

   // latch request on accept, capture read word when the latency count expires
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wword_q <= '0;
         size_q <= '0;
         cnt <= '0;
         write_q <= 1'b0;
         sign_q <= 1'b0;
         fault_q <= 1'b0;
      end else if (accept) begin
         addr_q <= req_addr;
         wdata_q <= req_wdata;
         wword_q <= req_wdata;
         size_q <= req_size;
         cnt <= 8'd1;
         write_q <= req_write;
         sign_q <= req_signed;
         fault_q <= fault;
      end else if (state == READ) begin
         cnt <= cnt + 8'd1;
         if (last) begin
            rdata_q <= load_data;
            wword_q <= merged;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector bench run against READ_LATENCY 1 and 3
module tb_mem_access_unit;
   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] rdata;
      logic        flt;
      int          base;
      logic        addl;
      logic        wexp;
      logic [31:0] wval;
   } vec_t;

   logic clk;
   int   total = 0;
   int   bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s L=%0d actual=%h required=%h", name, l, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int L = (g == 0) ? 1 : 3;
      logic        rst_n, req_valid, req_ready, req_write, req_signed;
      logic        resp_valid, resp_fault, mem_write, fin, pend;
      logic [1:0]  req_size;
      logic [31:0] req_addr, req_wdata, resp_rdata, mem_address, mem_data_out, mem_data_in;
      logic [31:0] last_a, pa, pd;
      logic [31:0] mem [logic [29:0]];
      int          age;
      vec_t        vt [16];

      mem_access_unit #(.ROM_END(64000), .READ_LATENCY(L)) dut (
         .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
         .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
         .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
         .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_address(mem_address),
         .mem_write(mem_write), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
      );

      initial begin
         last_a = '1;
         age = 0;
         pend = 1'b0;
         pa = '0;
         pd = '0;
         mem_data_in = '0;
      end

      // memory returns data only once the address has been stable for L cycles
      always @(negedge clk) begin
         if (mem_address != last_a) begin
            last_a = mem_address;
            age = 1;
         end else age++;
         mem_data_in = (age >= L) ? (mem.exists(mem_address[31:2]) ? mem[mem_address[31:2]] : 32'h0) : 32'hBAD0_BAD0;
         if (mem_write) begin
            pend = 1'b1;
            pa = mem_address;
            pd = mem_data_out;
         end
      end

      // a write takes effect at the clock edge ending its cycle unless reset intervened
      always @(posedge clk) begin
         if (pend) begin
            if (rst_n) mem[pa[31:2]] = pd;
            pend = 1'b0;
         end
      end

      task automatic run(input vec_t v, input int idx);
         int rc, nw;
         logic [31:0] rd, wa, wd;
         logic f, aok;
         rc = -1; nw = 0; rd = '0; wa = '0; wd = '0; f = 1'b0; aok = 1'b1;
         mem[v.addr[31:2]] = v.init;
         @(negedge clk);
         chk($sformatf("v%0d_ready", idx), L, {31'b0, req_ready}, 32'd1);
         req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
         req_addr = v.addr; req_wdata = v.wdata;
         @(posedge clk);
         #1 req_valid = 1'b0;
         for (int c = 1; c <= 12 && rc < 0; c++) begin
            @(negedge clk);
            if (mem_write) begin
               nw++;
               wa = mem_address;
               wd = mem_data_out;
            end
            if (mem_address != 0 && mem_address != {v.addr[31:2], 2'b00}) aok = 1'b0;
            if (resp_valid) begin
               rc = c;
               rd = resp_rdata;
               f = resp_fault;
            end
         end
         chk($sformatf("v%0d_cycle", idx), L, 32'(rc), 32'(v.base + (v.addl ? L : 0)));
         chk($sformatf("v%0d_rdata", idx), L, rd, v.rdata);
         chk($sformatf("v%0d_fault", idx), L, {31'b0, f}, {31'b0, v.flt});
         chk($sformatf("v%0d_nwrites", idx), L, 32'(nw), {31'b0, v.wexp});
         chk($sformatf("v%0d_addr_ok", idx), L, {31'b0, aok}, 32'd1);
         if (v.wexp) begin
            chk($sformatf("v%0d_waddr", idx), L, wa, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_wdata", idx), L, wd, v.wval);
         end
         chk($sformatf("v%0d_mem", idx), L, mem[v.addr[31:2]], v.wexp ? v.wval : v.init);
      endtask

      initial begin
         int r1, r2, acc, nr;
         logic [31:0] rd2;
         logic seen;
         fin = 1'b0;
         vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        32'h8899AABB, 32'h8899AABB, 1'b0, 1, 1'b1, 1'b0, 32'h0};
         vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h10003, 32'h0,        32'h80FF7F01, 32'hFFFFFF80, 1'b0, 1, 1'b1, 1'b0, 32'h0};
         vt[2]  = '{1'b0, 2'd0, 1'b0, 32'h10003, 32'h0,        32'h80FF7F01, 32'h00000080, 1'b0, 1, 1'b1, 1'b0, 32'h0};
         vt[3]  = '{1'b0, 2'd1, 1'b1, 32'h10002, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 1'b0, 1, 1'b1, 1'b0, 32'h0};
         vt[4]  = '{1'b0, 2'd1, 1'b0, 32'h10000, 32'h0,        32'h80FF7F01, 32'h00007F01, 1'b0, 1, 1'b1, 1'b0, 32'h0};
         vt[5]  = '{1'b0, 2'd0, 1'b1, 32'h10001, 32'h0,        32'h80FF7F01, 32'h0000007F, 1'b0, 1, 1'b1, 1'b0, 32'h0};
         vt[6]  = '{1'b1, 2'd0, 1'b0, 32'h10001, 32'h000000A5, 32'h11223344, 32'h0,        1'b0, 2, 1'b1, 1'b1, 32'h1122A544};
         vt[7]  = '{1'b1, 2'd1, 1'b0, 32'h10002, 32'h1234BEEF, 32'h11223344, 32'h0,        1'b0, 2, 1'b1, 1'b1, 32'hBEEF3344};
         vt[8]  = '{1'b1, 2'd2, 1'b0, 32'h20000, 32'hCAFEF00D, 32'h01020304, 32'h0,        1'b0, 2, 1'b0, 1'b1, 32'hCAFEF00D};
         vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h10002, 32'h0,        32'h55555555, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0};
         vt[10] = '{1'b1, 2'd1, 1'b0, 32'h10001, 32'h0000FFFF, 32'h55555555, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0};
         vt[11] = '{1'b0, 2'd3, 1'b0, 32'h10000, 32'h0,        32'h55555555, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0};
         vt[12] = '{1'b1, 2'd2, 1'b0, 32'h40,    32'h12345678, 32'h55555555, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0};
         vt[13] = '{1'b1, 2'd0, 1'b0, 32'hF9FF,  32'h00000077, 32'h55555555, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0};
         vt[14] = '{1'b1, 2'd0, 1'b0, 32'hFA00,  32'h00000077, 32'h55555555, 32'h0,        1'b0, 2, 1'b1, 1'b1, 32'h55555577};
         vt[15] = '{1'b0, 2'd2, 1'b0, 32'h40,    32'h0,        32'h0BADF00D, 32'h0BADF00D, 1'b0, 1, 1'b1, 1'b0, 32'h0};
         rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
         req_addr = '0; req_wdata = '0;
         repeat (2) @(negedge clk);
         chk("rst_ready", L, {31'b0, req_ready}, 32'd1);
         chk("rst_resp_valid", L, {31'b0, resp_valid}, 32'd0);
         chk("rst_resp_fault", L, {31'b0, resp_fault}, 32'd0);
         chk("rst_rdata", L, resp_rdata, 32'd0);
         chk("rst_mem_address", L, mem_address, 32'd0);
         chk("rst_mem_write", L, {31'b0, mem_write}, 32'd0);
         chk("rst_mem_data_out", L, mem_data_out, 32'd0);
         rst_n = 1'b1;
         for (int i = 0; i < 16; i++) run(vt[i], i);
         mem[30'h4000] = 32'h0;
         @(negedge clk);
         req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
         req_addr = 32'h10000; req_wdata = 32'hDEADBEEF;
         @(posedge clk);
         #1 req_write = 1'b0; req_wdata = '0;
         r1 = -1; r2 = -1; acc = -1; rd2 = '0;
         for (int c = 1; c <= 20 && r2 < 0; c++) begin
            @(negedge clk);
            if (resp_valid && r1 < 0) r1 = c;
            else if (resp_valid) begin
               r2 = c;
               rd2 = resp_rdata;
            end
            if (req_ready && acc < 0) begin
               acc = c;
               @(posedge clk);
               #1 req_valid = 1'b0;
            end
         end
         req_valid = 1'b0;
         chk("b2b_first_resp", L, 32'(r1), 32'd2);
         chk("b2b_accept", L, 32'(acc), 32'd3);
         chk("b2b_second_resp", L, 32'(r2), 32'(4 + L));
         chk("b2b_rdata", L, rd2, 32'hDEADBEEF);
         mem[30'h4000] = 32'h11223344;
         @(negedge clk);
         req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h10001; req_wdata = 32'hA5;
         @(posedge clk);
         #1 req_valid = 1'b0;
         seen = 1'b0;
         for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            seen = mem_write;
         end
         chk("rst_saw_write", L, {31'b0, seen}, 32'd1);
         #1 rst_n = 1'b0;
         #1;
         chk("rst_abort_write", L, {31'b0, mem_write}, 32'd0);
         chk("rst_abort_resp", L, {31'b0, resp_valid}, 32'd0);
         chk("rst_abort_ready", L, {31'b0, req_ready}, 32'd1);
         chk("rst_abort_addr", L, mem_address, 32'd0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         nr = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nr += int'(resp_valid);
         end
         chk("rst_no_resp", L, 32'(nr), 32'd0);
         chk("rst_release_ready", L, {31'b0, req_ready}, 32'd1);
         chk("rst_mem_intact", L, mem[30'h4000], 32'h11223344);
         fin = 1'b1;
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(inst[0].fin && inst[1].fin) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      if (!(inst[0].fin && inst[1].fin)) begin
         total++;
         bad++;
         $display("FAIL timeout actual=%0d cycles required=completion", t);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
